// File: rtl/digits_pkg.sv
// Shared constants for the digit text path: glyph codes, ROM layout and glyph geometry.
package digits_pkg;

    typedef logic [3:0] glyph_code_t;

    localparam glyph_code_t GLYPH_DASH  = 4'd10;
    localparam glyph_code_t GLYPH_A     = 4'd11;
    localparam glyph_code_t GLYPH_N     = 4'd12;
    localparam glyph_code_t GLYPH_BLANK = 4'd15;

    localparam logic [2:0]  ROM_BASE      = 3'b011;
    localparam logic [10:0] ROM_IDLE_ADDR = {ROM_BASE, 8'h00};

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    // Codes 13 and 14 have no glyph artwork and draw as background, like 15.
    function automatic logic is_blank_code(input glyph_code_t code);
        return code >= 4'd13;
    endfunction

endpackage

// File: rtl/digit_char_buffer.sv
// Double-buffered character store: CPU writes the shadow copy, the active copy is
// refreshed from shadow only on a frame_tick after a commit request.
module digit_char_buffer
    import digits_pkg::*;
#(
    parameter int NUM_CHARS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [3:0]  wr_code,
    input  logic        commit_req,
    input  logic        frame_tick,
    input  logic [3:0]  rd_slot,
    output glyph_code_t rd_code,
    output logic        commit_pending
);

    localparam logic [4:0] SLOT_LIMIT = 5'(NUM_CHARS);

    glyph_code_t r_shadow [16];
    glyph_code_t r_active [16];
    logic        r_pending;
    logic        w_wr_ok;

    assign w_wr_ok = wr_en && ({1'b0, wr_idx} < SLOT_LIMIT);

    // The copy reads shadow before this edge's write lands, so a same-cycle write stays in shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= GLYPH_BLANK;
                r_active[i] <= GLYPH_BLANK;
            end
            r_pending <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_shadow[wr_idx] <= wr_code;
            end
            if (r_pending && frame_tick) begin
                for (int i = 0; i < 16; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_pending <= 1'b0;
            end else if (commit_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign rd_code        = ({1'b0, rd_slot} < SLOT_LIMIT) ? r_active[rd_slot] : GLYPH_BLANK;
    assign commit_pending = r_pending;

endmodule

// File: rtl/digit_text_renderer.sv
// Renders one line of NUM_CHARS 8x16 glyphs from the digit ROM into the VGA pixel stream.
// Optional build macro CURSOR_BLINK_EN adds a blinking inverse-video cursor slot.
module digit_text_renderer
    import digits_pkg::*;
#(
    parameter int          NUM_CHARS = 8,
    parameter int          X0        = 256,
    parameter int          Y0        = 224,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_tick,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [3:0]  wr_code,
    input  logic        commit_req,
`ifdef CURSOR_BLINK_EN
    input  logic [3:0]  cursor_idx,
    input  logic        cursor_on,
`endif
    output logic        commit_pending,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + GLYPH_W * NUM_CHARS);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + GLYPH_H);

    function automatic logic [11:0] pick_color(input logic lit, input logic swap);
        return (lit ^ swap) ? FG_COLOR : BG_COLOR;
    endfunction

    // ---- stage 0: region decode and ROM address
    logic [6:0]  w_dx_p0;
    logic [3:0]  w_dy_p0;
    logic        w_in_region_p0;
    logic [3:0]  w_slot_p0;
    logic [2:0]  w_col_p0;
    glyph_code_t w_code_p0;
    logic        w_swap_p0;

    // Only the low bits of dx/dy feed slot/col/row inside the region, so the
    // subtraction is kept to those bits.
    assign w_dx_p0 = pixel_x[6:0] - X_LO[6:0];
    assign w_dy_p0 = pixel_y[3:0] - Y_LO[3:0];

    assign w_in_region_p0 = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                            ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
    assign w_slot_p0 = w_dx_p0[6:3];
    assign w_col_p0  = w_dx_p0[2:0];

    digit_char_buffer #(
        .NUM_CHARS (NUM_CHARS)
    ) u_char_buffer (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_code        (wr_code),
        .commit_req     (commit_req),
        .frame_tick     (frame_tick),
        .rd_slot        (w_slot_p0),
        .rd_code        (w_code_p0),
        .commit_pending (commit_pending)
    );

    assign rom_addr = w_in_region_p0 ? {ROM_BASE, w_code_p0, w_dy_p0} : ROM_IDLE_ADDR;

`ifdef CURSOR_BLINK_EN
    logic [5:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= 6'd0;
        end else if (frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    assign w_swap_p0 = w_in_region_p0 && cursor_on && r_frame_cnt[5] && (w_slot_p0 == cursor_idx);
`else
    assign w_swap_p0 = 1'b0;
`endif

    // ---- stage 1: ROM data returns; control travels alongside
    logic       r_in_region_p1;
    logic [2:0] r_col_p1;
    logic       r_blank_p1;
    logic       r_swap_p1;
    logic       r_vld_p1;
    logic       r_hs_p1;
    logic       r_vs_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_region_p1 <= 1'b0;
            r_col_p1       <= 3'd0;
            r_blank_p1     <= 1'b0;
            r_swap_p1      <= 1'b0;
            r_vld_p1       <= 1'b0;
            r_hs_p1        <= 1'b1;
            r_vs_p1        <= 1'b1;
        end else begin
            r_in_region_p1 <= w_in_region_p0;
            r_col_p1       <= w_col_p0;
            r_blank_p1     <= is_blank_code(w_code_p0);
            r_swap_p1      <= w_swap_p0;
            r_vld_p1       <= video_on;
            r_hs_p1        <= hsync_in;
            r_vs_p1        <= vsync_in;
        end
    end

    logic w_glyph_bit_p1;
    logic w_lit_p1;

    assign w_glyph_bit_p1 = rom_data[3'd7 - r_col_p1];
    assign w_lit_p1       = r_in_region_p1 && !r_blank_p1 && w_glyph_bit_p1;

    // ---- stage 2: registered pixel colour and aligned syncs
    logic [11:0] r_rgb_p2;
    logic        r_hs_p2;
    logic        r_vs_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb_p2 <= 12'h000;
            r_hs_p2  <= 1'b1;
            r_vs_p2  <= 1'b1;
        end else begin
            r_rgb_p2 <= r_vld_p1 ? pick_color(w_lit_p1, r_swap_p1) : 12'h000;
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
        end
    end

    assign rgb       = r_rgb_p2;
    assign hsync_out = r_hs_p2;
    assign vsync_out = r_vs_p2;

endmodule

// File: tb/tb_digit_text_renderer.sv
// Directed bench for digit_text_renderer with a glyph ROM stand-in and a pixel-level reference model.
module tb_digit_text_renderer;

    localparam int          NC = 8;
    localparam int          X0 = 256;
    localparam int          Y0 = 224;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h124;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  pixel_x = 10'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        frame_tick = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = 4'd0;
    logic [3:0]  wr_code = 4'd0;
    logic        commit_req = 1'b0;
    logic        commit_pending;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    digit_text_renderer #(
        .NUM_CHARS (NC),
        .X0        (X0),
        .Y0        (Y0),
        .FG_COLOR  (FG),
        .BG_COLOR  (BG)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .video_on       (video_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .frame_tick     (frame_tick),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_code        (wr_code),
        .commit_req     (commit_req),
`ifdef CURSOR_BLINK_EN
        .cursor_idx     (4'd0),
        .cursor_on      (1'b0),
`endif
        .commit_pending (commit_pending),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rgb            (rgb),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out)
    );

    // Glyph ROM stand-in: digit 1 row 2 is 00011000, the idle address is all-ones,
    // everything else a fixed scramble.
    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        int code;
        int row;
        code = int'(a[7:4]);
        row  = int'(a[3:0]);
        if (a[10:8] != 3'b011) return 8'h00;
        if (code == 1 && row == 2) return 8'h18;
        if (code == 0 && row == 0) return 8'hFF;
        return 8'((code * 16 + row) * 37) ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Reference model state
    logic [3:0]  m_shadow [16];
    logic [3:0]  m_active [16];
    logic        m_pending;
    logic [11:0] m_rgb_p1, m_rgb_p2;
    logic        m_hs_p1, m_hs_p2, m_vs_p1, m_vs_p2;

    function automatic int text_slot(input int x, input int y);
        if (x >= X0 && x < X0 + 8 * NC && y >= Y0 && y < Y0 + 16) return (x - X0) / 8;
        return -1;
    endfunction

    function automatic logic [10:0] exp_addr(input int x, input int y);
        int s;
        s = text_slot(x, y);
        if (s < 0) return 11'h300;
        return 11'(768 + int'(m_active[s]) * 16 + (y - Y0));
    endfunction

    function automatic logic [11:0] exp_pixel(input int x, input int y, input logic von);
        int s;
        int c;
        logic [7:0] glyph;
        if (!von) return 12'h000;
        s = text_slot(x, y);
        if (s < 0) return BG;
        c = int'(m_active[s]);
        if (c >= 13) return BG;
        glyph = rom_fn(exp_addr(x, y));
        return glyph[7 - (x - X0) % 8] ? FG : BG;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                m_shadow[i] <= 4'd15;
                m_active[i] <= 4'd15;
            end
            m_pending <= 1'b0;
            m_rgb_p1  <= 12'h000;
            m_rgb_p2  <= 12'h000;
            m_hs_p1   <= 1'b1;
            m_hs_p2   <= 1'b1;
            m_vs_p1   <= 1'b1;
            m_vs_p2   <= 1'b1;
        end else begin
            m_rgb_p1 <= exp_pixel(int'(pixel_x), int'(pixel_y), video_on);
            m_rgb_p2 <= m_rgb_p1;
            m_hs_p1  <= hsync_in;
            m_hs_p2  <= m_hs_p1;
            m_vs_p1  <= vsync_in;
            m_vs_p2  <= m_vs_p1;
            if (wr_en && int'(wr_idx) < NC) m_shadow[wr_idx] <= wr_code;
            if (frame_tick && m_pending) begin
                for (int i = 0; i < 16; i++) m_active[i] <= m_shadow[i];
                m_pending <= 1'b0;
            end else if (commit_req) begin
                m_pending <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("rgb", 32'(rgb), 32'(m_rgb_p2));
        check("hsync_out", 32'(hsync_out), 32'(m_hs_p2));
        check("vsync_out", 32'(vsync_out), 32'(m_vs_p2));
        check("commit_pending", 32'(commit_pending), 32'(m_pending));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr(int'(pixel_x), int'(pixel_y))));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int idx, input int code);
        wr_en   = 1'b1;
        wr_idx  = 4'(idx);
        wr_code = 4'(code);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic scan(input int y, input int x_first, input int n);
        video_on = 1'b1;
        pixel_y  = 10'(y);
        for (int i = 0; i < n; i++) begin
            pixel_x = 10'(x_first + i);
            tick();
        end
        video_on = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b00011000;

        // Reset held from time zero
        repeat (3) tick();
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_pending", 32'(commit_pending), 32'h0);
        check("reset_hsync", 32'(hsync_out), 32'h1);
        reset_n = 1'b1;
        tick();
        scan(Y0, X0 - 4, 8 * NC + 8);
        scan(Y0 + 15, X0, 8 * NC);

        // Digit 1 in slot 0, row 2
        write_slot(0, 1);
        pulse_commit();
        check("pending_set", 32'(commit_pending), 32'h1);
        pulse_frame();
        check("pending_clear", 32'(commit_pending), 32'h0);
        video_on = 1'b1;
        pixel_y  = 10'(Y0 + 2);
        for (int i = 0; i < 10; i++) begin
            pixel_x = 10'(X0 + i);
            if (i == 0) begin
                #1;
                check("rom_addr_digit1", 32'(rom_addr), 32'h312);
            end
            tick();
            if (i >= 1 && i <= 8) check("digit1_row2", 32'(rgb), 32'(pat[8 - i] ? FG : BG));
        end
        video_on = 1'b0;
        tick();
        tick();

        // Shadow write without commit stays invisible
        write_slot(3, 11);
        check("no_commit_pending", 32'(commit_pending), 32'h0);
        pulse_frame();
        pulse_frame();
        check("no_commit_pending2", 32'(commit_pending), 32'h0);
        pixel_x = 10'(X0 + 24);
        pixel_y = 10'(Y0 + 5);
        #1;
        check("rom_addr_slot3_blank", 32'(rom_addr), 32'h3F5);
        scan(Y0 + 5, X0 + 24, 8);

        // commit_req and frame_tick together only arm the commit
        commit_req = 1'b1;
        frame_tick = 1'b1;
        tick();
        commit_req = 1'b0;
        frame_tick = 1'b0;
        check("same_cycle_pending", 32'(commit_pending), 32'h1);
        scan(Y0 + 5, X0 + 24, 8);

        // Copying frame_tick with a same-cycle write to slot 2
        frame_tick = 1'b1;
        wr_en      = 1'b1;
        wr_idx     = 4'd2;
        wr_code    = 4'd8;
        tick();
        frame_tick = 1'b0;
        wr_en      = 1'b0;
        check("copy_pending_clear", 32'(commit_pending), 32'h0);
        pixel_x = 10'(X0 + 16);
        pixel_y = 10'(Y0);
        #1;
        check("rom_addr_slot2_old", 32'(rom_addr), 32'h3F0);
        pixel_x = 10'(X0 + 24);
        pixel_y = 10'(Y0 + 5);
        #1;
        check("rom_addr_slot3_A", 32'(rom_addr), 32'h3B5);
        for (int r = 0; r < 16; r += 5) scan(Y0 + r, X0 - 2, 8 * NC + 4);
        pulse_commit();
        pulse_frame();
        pixel_x = 10'(X0 + 16);
        pixel_y = 10'(Y0);
        #1;
        check("rom_addr_slot2_new", 32'(rom_addr), 32'h380);

        // Stored-but-blank codes, out-of-range index, dash and N glyphs
        write_slot(4, 13);
        write_slot(5, 14);
        write_slot(6, 10);
        write_slot(7, 12);
        write_slot(9, 5);
        pulse_commit();
        pulse_frame();
        for (int r = 0; r < 16; r++) scan(Y0 + r, X0 - 1, 8 * NC + 2);

        // Right edge: idle ROM row is all-ones but must never light a pixel
        video_on = 1'b1;
        pixel_y  = 10'(Y0);
        pixel_x  = 10'(X0 + 8 * NC);
        tick();
        tick();
        check("right_edge_bg", 32'(rgb), 32'(BG));

        // hsync and video_on latency: exactly two cycles
        hsync_in = 1'b0;
        video_on = 1'b0;
        tick();
        hsync_in = 1'b1;
        video_on = 1'b1;
        check("hsync_lat1", 32'(hsync_out), 32'h1);
        check("blank_lat1", 32'(rgb), 32'(BG));
        tick();
        check("hsync_lat2", 32'(hsync_out), 32'h0);
        check("blank_lat2", 32'(rgb), 32'h0);
        tick();
        check("hsync_lat3", 32'(hsync_out), 32'h1);
        check("blank_lat3", 32'(rgb), 32'(BG));
        vsync_in = 1'b0;
        tick();
        tick();
        vsync_in = 1'b1;
        tick();
        tick();
        tick();

        // Reset mid-frame with a commit armed
        pulse_commit();
        check("armed_before_reset", 32'(commit_pending), 32'h1);
        pixel_x  = 10'(X0 + 3);
        pixel_y  = 10'(Y0 + 2);
        video_on = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midreset_pending", 32'(commit_pending), 32'h0);
        check("midreset_rgb", 32'(rgb), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        scan(Y0 + 2, X0, 8 * NC);
        pulse_frame();
        check("post_reset_pending", 32'(commit_pending), 32'h0);
        scan(Y0 + 2, X0, 8 * NC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
